imem_loader: RTL
================

Name: imem_loader

Overview:
- Program loader: the writer side of the instruction memory that the CPU core only reads.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes each word into instruction memory through a single write port.
- Holds the core in reset until the image is complete.
- Sits beside the CPU core: its outputs drive the instruction-memory write port and gate the core's reset.

Parameters:
DATA_WIDTH, 32, instruction word width; must be 32.
ADDRESS_WIDTH, 12, byte-address width of instruction memory; depth = 2**(ADDRESS_WIDTH-2) words.
BASE_ADDR, 0, byte address of the first loaded word; must be word-aligned.
TIMEOUT_CYCLES, 1024, idle cycles allowed between accepted bytes once a load has started.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
rx_valid  input  1  byte source has rx_data available.
rx_data  input  8  incoming byte.
rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready.
wr_en  output  1  one-cycle instruction-memory write strobe.
wr_addr  output  ADDRESS_WIDTH  byte address of the write.
wr_data  output  DATA_WIDTH  word to write.
cpu_hold  output  1  high keeps the core in reset.
done  output  1  image fully written; sticky.
error  output  1  load aborted; sticky.

Behaviour:
- Reset values: rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0. The state register goes to HDR, and the word index and timeout counter clear.
- Image format: 2 header bytes giving word count N (16-bit, little-endian), then N words of 4 bytes each, little-endian. Byte k of a word lands in bits [8k+7:8k].
- States: HDR -> DATA -> WRITE -> (DATA | DONE); any state can go to ERR as listed below.
- HDR:
  - rx_ready=1; collect 2 bytes.
  - After the 2nd byte: if N==0, go to DONE; if N > depth, go to ERR; otherwise go to DATA with index=0.
- DATA:
  - rx_ready=1; collect 4 bytes.
  - The cycle after the 4th byte is accepted, go to WRITE.
- WRITE:
  - rx_ready=0, wr_en=1 for exactly one cycle.
  - wr_addr = BASE_ADDR + 4*index, truncated to ADDRESS_WIDTH; wr_data = the assembled word.
  - Increment index; if the new index == N go to DONE, else go to DATA.
  - Latency from accepting the 4th byte to wr_en high: 1 cycle.
- DONE: rx_ready=0, cpu_hold=0, done=1. Held until rst.
- ERR: rx_ready=0, cpu_hold=1, error=1. Held until rst; no further wr_en.
- Timeout:
  - Armed once the first header byte has been accepted; counts cycles in HDR/DATA with no accepted byte.
  - Cleared on every accepted byte.
  - Reaching TIMEOUT_CYCLES goes to ERR.
  - In HDR before any byte arrives, the loader waits indefinitely.
- While rx_ready=0, rx_valid is ignored and the byte is not consumed; the source must hold it.
- wr_en is never high in the same cycle as rx_ready.
- Reset mid-load:
  - Aborts immediately; outputs take reset values on the next edge.
  - Words already written stay in memory; the next load restarts at BASE_ADDR.
- The core only ever sees cpu_hold fall once per reset, via DONE.

Decomposition:
- Shared package loader_pkg:
  - State enum: HDR, DATA, WRITE, DONE, ERR.
  - Constants: HDR_BYTES=2, WORD_BYTES=4.
  - Timeout counter width function $clog2(TIMEOUT_CYCLES+1).
- One sub-module, byte_assembler: 2-bit byte counter plus 32-bit little-endian shift/insert register with clear and word_complete outputs. It is reused for the 16-bit header by reading the low half.

Test Plan:
- Normal load:
  - Stimulus: stream 02 00 | 13 05 A0 00 | 6F 00 00 00.
  - Required: wr_en at addr 0x000 with data 0x00A00513, then at addr 0x004 with data 0x0000006F; then done=1, cpu_hold=0, rx_ready=0.
- Empty image:
  - Stimulus: stream 00 00.
  - Required: no wr_en; done=1 one cycle after the 2nd byte is accepted.
- Backpressure:
  - Stimulus: N=2, with rx_valid held high continuously and the next word's first byte presented during WRITE.
  - Required: that byte is not consumed until rx_ready returns; written data is still correct.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; send 01 00 AA BB, then stall 16 cycles.
  - Required: error=1, cpu_hold=1, no wr_en ever.
- Oversize:
  - Stimulus: ADDRESS_WIDTH=6 (depth 16); header 11 00 (N=17).
  - Required: error=1 after the 2nd byte; no writes.
- Reset mid-load:
  - Stimulus: N=3; assert rst one cycle after the first wr_en, then reload N=1 with word 0x00000013.
  - Required: all outputs at reset values next cycle; the new write lands at addr 0x000; then done=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   state_e        : loader FSM states
//   HDR_BYTES      : bytes in the image header (16-bit word count)
//   WORD_BYTES     : bytes per instruction word
//   timeout_width  : counter width able to hold the value TIMEOUT_CYCLES
package loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  function automatic int timeout_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word assembler.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   clear_i           : drop any partial word, restart at byte 0 (wins over valid_i)
//   valid_i, byte_i   : one accepted byte
//   cnt_o             : index of the byte slot the next byte will fill
//   word_o            : assembled word so far
//   word_nxt_o        : word_o with byte_i already inserted (same-cycle view)
//   word_complete_o   : byte_i is the last byte of a word
// Byte k of a word lands in bits [8k+7:8k]; the header reuses the low half.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  cnt_o,
  output logic [31:0] word_o,
  output logic [31:0] word_nxt_o,
  output logic        word_complete_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d, ins;

  always_comb begin
    ins = word_q;
    ins[8*cnt_q +: 8] = byte_i;
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (valid_i) begin
      cnt_d  = cnt_q + 2'd1;  // wraps to 0 after the 4th byte
      word_d = ins;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign cnt_o           = cnt_q;
  assign word_o          = word_q;
  assign word_nxt_o      = ins;
  assign word_complete_o = valid_i && !clear_i && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Program loader: writer side of the instruction memory.
//   clk, rst           : clock, synchronous active-high reset
//   rx_valid/rx_data   : incoming byte stream; rx_ready accepts a byte
//   wr_en/addr/data    : one-cycle instruction-memory write port
//   cpu_hold           : keeps the core in reset until the image is complete
//   done / error       : sticky completion / abort flags (cleared only by rst)
// Image: 16-bit LE word count N, then N little-endian 32-bit words.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 12,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  localparam int DEPTH = 2 ** (ADDRESS_WIDTH - 2);
  localparam int TW    = timeout_width(TIMEOUT_CYCLES);

  state_e                   state_q, state_d;
  logic                     rx_ready_q, rx_ready_d;
  logic [15:0]              n_q, n_d;
  logic [15:0]              idx_q, idx_d;
  logic                     armed_q, armed_d;
  logic [TW-1:0]            to_q, to_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;

  logic        fire;
  logic        asm_clear;
  logic [1:0]  asm_cnt;
  logic [31:0] asm_word;
  logic [31:0] asm_nxt;
  logic        asm_complete;
  logic [15:0] hdr_n;
  logic [31:0] addr_full;

  assign fire      = rx_valid && rx_ready_q;
  assign hdr_n     = asm_nxt[15:0];
  assign addr_full = 32'(BASE_ADDR) + {14'd0, idx_q, 2'b00};

  byte_assembler u_asm (
    .clk_i           (clk),
    .rst_i           (rst),
    .clear_i         (asm_clear),
    .valid_i         (fire),
    .byte_i          (rx_data),
    .cnt_o           (asm_cnt),
    .word_o          (asm_word),
    .word_nxt_o      (asm_nxt),
    .word_complete_o (asm_complete)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    armed_d   = armed_q;
    to_d      = to_q;
    addr_d    = addr_q;
    data_d    = data_q;
    asm_clear = 1'b0;

    case (state_q)
      HDR: begin
        if (fire) begin
          armed_d = 1'b1;
          if (asm_cnt == 2'(HDR_BYTES - 1)) begin
            // Header consumed straight from the insert path; clear so the
            // first data byte lands in slot 0.
            asm_clear = 1'b1;
            n_d       = hdr_n;
            idx_d     = '0;
            if (hdr_n == 16'd0)          state_d = DONE;
            else if (int'(hdr_n) > DEPTH) state_d = ERR;
            else                          state_d = DATA;
          end
        end
      end
      DATA: begin
        if (asm_complete) begin
          state_d = WRITE;
          data_d  = asm_nxt;
          addr_d  = addr_full[ADDRESS_WIDTH-1:0];
        end
      end
      WRITE: begin
        asm_clear = 1'b1;
        idx_d     = idx_q + 16'd1;
        state_d   = (idx_d == n_q) ? DONE : DATA;
      end
      default: ;
    endcase

    // Inter-byte timeout: only once a load has begun, only while waiting on bytes.
    if (state_q == HDR || state_q == DATA) begin
      if (fire) begin
        to_d = '0;
      end else if (armed_q) begin
        to_d = to_q + TW'(1);
        if (to_d == TW'(TIMEOUT_CYCLES)) state_d = ERR;
      end
    end

    // Registered so rx_ready reads 0 out of reset and drops in lockstep with WRITE.
    rx_ready_d = (state_d == HDR) || (state_d == DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR;
      rx_ready_q <= 1'b0;
      n_q        <= '0;
      idx_q      <= '0;
      armed_q    <= 1'b0;
      to_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      armed_q    <= armed_d;
      to_q       <= to_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign wr_en    = (state_q == WRITE);
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign cpu_hold = (state_q != DONE);
  assign done     = (state_q == DONE);
  assign error    = (state_q == ERR);

endmodule
